// File: rtl/bram_fifo_ctrl.sv
// Purpose : valid/ready FIFO controller around one single-port BRAM with a
//           registered read port; a 2-entry output buffer hides the read latency.
// Latency : push at N -> read issued N+1 -> mem_dout N+2 -> m_valid N+3 (empty FIFO).
// Backpr. : s_ready drops when memory is full or the port is taken by a read;
//           the head is held while m_valid && !m_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   producer stream (push side)
//   m_valid/m_ready/m_data   consumer stream (pop side)
//   count               entries held (memory + read in flight + output buffer)
//   mem_wr/mem_addr/mem_din  BRAM port drive
//   mem_dout            BRAM registered read data
module bram_fifo_ctrl #(
    parameter int DATASIZE = 32,
    parameter int ADDRSIZE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATASIZE-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic [ADDRSIZE+1:0] count,
    output logic                mem_wr,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [DATASIZE-1:0] mem_din,
    input  logic [DATASIZE-1:0] mem_dout
);

    // The top address is never issued, so usable depth is one short of 2**ADDRSIZE.
    localparam int DEPTH = (1 << ADDRSIZE) - 1;
    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(DEPTH - 1);
    localparam logic [ADDRSIZE:0]   MEM_FULL  = (ADDRSIZE + 1)'(DEPTH);

    logic [ADDRSIZE-1:0] wr_ptr;
    logic [ADDRSIZE-1:0] rd_ptr;
    logic [ADDRSIZE:0]   mem_used;
    logic                inflight;
    logic [1:0]          out_occ;
    logic                prio_rd;
    logic [DATASIZE-1:0] buf_head;
    logic [DATASIZE-1:0] buf_tail;

    logic       pop;
    logic       push;
    logic       can_wr;
    logic       can_rd;
    logic       rd_sel;
    logic [2:0] pend;

    // ------------------------------------------------------------------
    // Port arbitration
    // ------------------------------------------------------------------
    always_comb begin
        pop    = m_valid && m_ready;
        // Entries that will occupy the output buffer once the in-flight read
        // lands; a new read is only allowed if it still has a slot to land in.
        pend   = {1'b0, out_occ} + {2'b00, inflight} - {2'b00, pop};
        can_wr = (mem_used < MEM_FULL);
        can_rd = (mem_used != '0) && (pend < 3'd2);
        rd_sel = can_rd && (prio_rd || !can_wr || !s_valid);
        s_ready = rst_n && can_wr && !rd_sel;
        push   = s_valid && s_ready;

        mem_wr   = push;
        mem_addr = push ? wr_ptr : rd_ptr;
        mem_din  = s_data;
    end

    assign m_valid = (out_occ != 2'd0);
    assign m_data  = buf_head;
    assign count   = (ADDRSIZE + 2)'(mem_used) + (ADDRSIZE + 2)'(inflight)
                   + (ADDRSIZE + 2)'(out_occ);

    // ------------------------------------------------------------------
    // Pointers, memory occupancy, arbitration priority
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_used <= '0;
            inflight <= 1'b0;
            prio_rd  <= 1'b0;
        end else begin
            inflight <= rd_sel;
            if (push) begin
                wr_ptr   <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDRSIZE'(1);
                mem_used <= mem_used + (ADDRSIZE + 1)'(1);
                prio_rd  <= 1'b1;
            end else if (rd_sel) begin
                rd_ptr   <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDRSIZE'(1);
                mem_used <= mem_used - (ADDRSIZE + 1)'(1);
                prio_rd  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: head/tail pair, filled from mem_dout the cycle after
    // a read was issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_occ  <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            unique case ({inflight, pop})
                2'b10: begin
                    if (out_occ == 2'd0) buf_head <= mem_dout;
                    else                 buf_tail <= mem_dout;
                    out_occ <= out_occ + 2'd1;
                end
                2'b01: begin
                    buf_head <= buf_tail;
                    out_occ  <= out_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word joins behind whatever
                    // remains after the pop.
                    if (out_occ == 2'd1) begin
                        buf_head <= mem_dout;
                    end else begin
                        buf_head <= buf_tail;
                        buf_tail <= mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = (1 << AW) - 1;
    localparam int CAP   = DEPTH + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Single-port BRAM with registered read data.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of accepted words in arrival order. The FIFO
    // holds exactly what was accepted and not yet taken; the head must be the
    // oldest; writes walk addresses 0..DEPTH-1 cyclically.
    // ------------------------------------------------------------------
    logic [DW-1:0] q[$];
    int            wr_n = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_mem_addr", mem_addr, 0);
            q.delete();
            wr_n = 0;
            stall_prev = 1'b0;
        end else begin
            chk("count", count, q.size());
            chk("addr_top_unused", mem_addr == AW'(DEPTH), 0);
            chk("mem_wr_is_push", mem_wr, s_valid && s_ready);
            if (q.size() == 0) chk("empty_no_valid", m_valid, 0);
            if (q.size() == CAP) chk("full_no_ready", s_ready, 0);
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, data_prev);
            end
            if (m_valid && q.size() > 0) chk("head_data", m_data, q[0]);
            if (mem_wr) begin
                chk("wr_addr", mem_addr, wr_n % DEPTH);
                chk("wr_din", mem_din, s_data);
                wr_n++;
            end
            if (m_valid && m_ready && q.size() > 0) void'(q.pop_front());
            if (s_valid && s_ready) q.push_back(s_data);
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
        end
    end

    task automatic wait_empty(input string nm);
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (count != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, count, 0);
    endtask

    // Continuous pushes with the consumer stalled until count reaches target.
    task automatic fill_to(input int target, input string nm);
        int n = 0;
        m_ready = 1'b0;
        while (count != target && n < 60) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(posedge clk); #1;
            n++;
        end
        chk(nm, count, target);
    endtask

    initial begin
        int nxt;
        int acc;
        int cyc;
        logic taken;
        logic wr_hist [20];

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- Single push latency on empty FIFO ----
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 32'hA5A5A5A5; m_ready = 1'b1;
        @(negedge clk);
        chk("lat_n_wr", mem_wr, 1);
        chk("lat_n_addr", mem_addr, 0);
        chk("lat_n_ready", s_ready, 1);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_wr", mem_wr, 0);
        chk("lat_n1_rdaddr", mem_addr, 0);
        chk("lat_n1_valid", m_valid, 0);
        chk("lat_n1_count", count, 1);
        @(negedge clk);
        chk("lat_n2_valid", m_valid, 0);
        @(negedge clk);
        chk("lat_n3_valid", m_valid, 1);
        chk("lat_n3_data", m_data, 32'hA5A5A5A5);
        @(negedge clk);
        chk("lat_n4_valid", m_valid, 0);
        chk("lat_n4_count", count, 0);

        // ---- Fill to capacity with stalled consumer ----
        nxt = 1; acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            m_ready = 1'b0;
            s_valid = (nxt <= 20);
            s_data  = nxt;
            @(negedge clk);
            if (s_valid && s_ready) begin acc++; nxt++; end
        end
        chk("full_accepted", acc, 9);
        chk("full_count", count, 9);
        chk("full_s_ready", s_ready, 0);
        chk("full_head", m_data, 1);

        // ---- From full: pop while pushing, read/write alternate ----
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = nxt;
            @(negedge clk);
            wr_hist[c] = mem_wr;
            if (s_valid && s_ready) nxt++;
        end
        for (int c = 0; c < 20; c++) chk("alternate", wr_hist[c], (c % 2) == 1);
        chk("alt_pushes", nxt, 20);
        @(posedge clk); #1;
        wait_empty("alt_drain");

        // ---- Random traffic, toggling consumer ----
        acc = 0; cyc = 0; taken = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            m_ready = ~m_ready;
            if (!s_valid || taken) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
                taken   = 1'b0;
            end
            @(negedge clk);
            if (s_valid && s_ready) begin acc++; taken = 1'b1; end
            cyc++;
        end
        chk("rand_pushes", acc, 1000);
        @(posedge clk); #1;
        wait_empty("rand_drain");
        chk("rand_model_empty", q.size(), 0);

        // ---- Asynchronous reset mid-operation ----
        fill_to(6, "pre_rst_fill");
        s_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("pre_rst_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_s_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 32'h1; m_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_accept", s_ready, 1);
        @(posedge clk); #1 s_valid = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("post_rst_valid", m_valid, 1);
        chk("post_rst_data", m_data, 32'h1);
        @(posedge clk); #1;
        wait_empty("post_rst_drain");

        // ---- Idle producer drains 3 memory words back to back ----
        fill_to(5, "drain_fill");
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_valid_cont", m_valid, 1);
        end
        @(negedge clk);
        chk("drain_end_valid", m_valid, 0);
        chk("drain_end_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
